dilated_activation_cache: RTL

Upstream feeder for one conv1d layer of the cached dilated causal convolution stack. Stores the history of packed activation vectors in a circular buffer. For every new input vector it presents the four dilated taps x[t-3d], x[t-2d], x[t-d] and x[t] as packed_a0..packed_a3, which drive the layer's four kernel ports. Older taps not yet written read as zero (causal zero padding).

---
 rtl/dilated_cache_pkg.sv | 22 ++
 rtl/dilated_cache_ram.sv | 34 +++
 rtl/dilated_activation_cache.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dilated_cache_pkg.sv
// rtl/dilated_cache_pkg.sv - shared types and helpers for the dilated activation cache
// Contents: FSM state enum, tap count, modular pointer subtraction helper.
package dilated_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam int NUM_TAPS = 4;

  // (ptr - off) mod depth, adding depth first so no negative intermediate
  // appears; off is always < depth so one conditional subtract suffices.
  function automatic int wrap_sub(input int ptr, input int off, input int depth);
    int sum;
    sum = ptr + depth - off;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/dilated_cache_ram.sv
// rtl/dilated_cache_ram.sv - DEPTH x DW history storage, 1 sync write, 4 async reads
// Ports: clk; we/waddr/wdata write port; raddr0..3 -> rdata0..3 combinational reads.
// Contents are never reset; the owner masks stale entries.
module dilated_cache_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] raddr3,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] rdata3
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
  assign rdata3 = mem_q[raddr3];

endmodule

// File: rtl/dilated_activation_cache.sv
// rtl/dilated_activation_cache.sv - circular history feeding four dilated conv1d taps
// Ports: clk, rst (async, active-high); in_v/in_ready/packed_in accept x[t];
// packed_a0..a3 = x[t-3d], x[t-2d], x[t-d], x[t]; out_v held until out_ack.
// Optional macro CACHE_FLUSH_EN adds input flush to restart history from IDLE.
module dilated_activation_cache
  import dilated_cache_pkg::*;
#(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int DILATION = 1
) (
  input  logic           clk,
  input  logic           rst,
`ifdef CACHE_FLUSH_EN
  input  logic           flush,
`endif
  input  logic           in_v,
  output logic           in_ready,
  input  logic [D*W-1:0] packed_in,
  output logic [D*W-1:0] packed_a0,
  output logic [D*W-1:0] packed_a1,
  output logic [D*W-1:0] packed_a2,
  output logic [D*W-1:0] packed_a3,
  output logic           out_v,
  input  logic           out_ack
);

  localparam int DEPTH = 3 * DILATION + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = D * W;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] count_q, count_d;
  logic          out_v_q, out_v_d;
  // tap_q[k] holds x[t - k*DILATION]; k=0 is the newest sample.
  logic [DW-1:0] tap_q [NUM_TAPS];
  logic [DW-1:0] tap_d [NUM_TAPS];
  logic [AW-1:0] raddr [NUM_TAPS];
  logic [DW-1:0] rdata [NUM_TAPS];
  logic          ram_we;

`ifdef CACHE_FLUSH_EN
  assign in_ready = (state_q == IDLE) && !flush;
`else
  assign in_ready = (state_q == IDLE);
`endif

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_raddr
    assign raddr[k] = AW'(wrap_sub(int'(wptr_q), k * DILATION, DEPTH));
  end

  dilated_cache_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (wptr_q),
    .wdata  (packed_in),
    .raddr0 (raddr[0]),
    .raddr1 (raddr[1]),
    .raddr2 (raddr[2]),
    .raddr3 (raddr[3]),
    .rdata0 (rdata[0]),
    .rdata1 (rdata[1]),
    .rdata2 (rdata[2]),
    .rdata3 (rdata[3])
  );

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    out_v_d = out_v_q;
    ram_we  = 1'b0;
    for (int k = 0; k < NUM_TAPS; k++) tap_d[k] = tap_q[k];

    case (state_q)
      IDLE: begin
`ifdef CACHE_FLUSH_EN
        if (flush) begin
          wptr_d  = '0;
          count_d = '0;
        end
`endif
        if (in_v && in_ready) begin
          ram_we  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        // count is the number of valid samples before x[t]; anything older
        // than that reads as causal zero padding.
        for (int k = 0; k < NUM_TAPS; k++) begin
          tap_d[k] = (k * DILATION <= int'(count_q)) ? rdata[k] : '0;
        end
        wptr_d  = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        count_d = (count_q == AW'(3 * DILATION)) ? count_q : count_q + 1'b1;
        out_v_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (out_ack) begin
          out_v_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      out_v_q <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      out_v_q <= out_v_d;
      for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= tap_d[k];
    end
  end

  assign out_v     = out_v_q;
  assign packed_a3 = tap_q[0];
  assign packed_a2 = tap_q[1];
  assign packed_a1 = tap_q[2];
  assign packed_a0 = tap_q[3];

endmodule
